// File: rtl/muldiv_alu.sv
// muldiv_alu: single-cycle ALU plus iterative shift-add multiplier and optional restoring divider (MULDIV_ALU_DIV_EN)
module muldiv_alu #(
  parameter int WIDTH    = 32,
  parameter int SH_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUctrl,
  input  logic             start,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             EQ,
  output logic             LT,
  output logic             LTU
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                 state_q, state_d;
  logic [3:0]             op_q;
  logic [WIDTH-1:0]       opnd_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [SH_WIDTH-1:0]    cnt_q;
  logic [WIDTH-1:0]       res_q;
  logic [WIDTH-1:0]       alu_r;
  logic [SH_WIDTH-1:0]    shamt;
  logic                   is_mul_in, is_div_in, iter_req, last;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_nx, step_nx;
  logic [WIDTH-1:0]       iter_res;
  assign EQ        = SrcA == SrcB;
  assign LT        = $signed(SrcA) < $signed(SrcB);
  assign LTU       = SrcA < SrcB;
  assign ALUResult = res_q;
  assign shamt     = SrcB[SH_WIDTH-1:0];
  assign is_mul_in = ALUctrl[3:1] == 3'b101;
`ifdef MULDIV_ALU_DIV_EN
  assign is_div_in = ALUctrl[3:1] == 3'b110;
`else
  assign is_div_in = 1'b0;
`endif
  assign iter_req  = is_mul_in | is_div_in;
  assign last      = cnt_q == SH_WIDTH'(WIDTH - 1);
  // single-cycle result from the live operands, registered on acceptance
  always_comb begin
    alu_r = '0;
    case (ALUctrl)
      4'b0000: alu_r = SrcA + SrcB;
      4'b0001: alu_r = SrcA - SrcB;
      4'b0010: alu_r = SrcA & SrcB;
      4'b0011: alu_r = SrcA | SrcB;
      4'b0100: alu_r = SrcA ^ SrcB;
      4'b0101: alu_r = SrcA << shamt;
      4'b0110: alu_r = SrcA >> shamt;
      4'b0111: alu_r = $signed(SrcA) >>> shamt;
      4'b1000: alu_r = {{(WIDTH-1){1'b0}}, LT};
      4'b1001: alu_r = {{(WIDTH-1){1'b0}}, LTU};
      default: alu_r = '0;
    endcase
  end
  // one iteration step: acc_q holds {hi, lo}; hi is partial product / remainder, lo is multiplier / quotient
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_ALU_DIV_EN
    begin
      logic [WIDTH:0] div_sh, div_diff;
      logic           div_ge;
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, opnd_q};
      div_ge   = div_sh >= {1'b0, opnd_q};
      step_nx  = op_q[3:2] == 2'b11 ? {div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge} : mul_nx;
    end
`else
    step_nx  = mul_nx;
`endif
    iter_res = op_q[0] ? step_nx[2*WIDTH-1:WIDTH] : step_nx[WIDTH-1:0];
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (iter_req ? BUSY : DONE) : IDLE;
      BUSY:    state_d = last ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    ready = state_q == IDLE;
    done  = state_q == DONE;
  end
  // datapath: capture on acceptance, iterate in BUSY, load result when finishing
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else if (state_q == IDLE && start) begin
      op_q   <= ALUctrl;
      opnd_q <= is_div_in ? SrcB : SrcA;
      acc_q  <= {{WIDTH{1'b0}}, is_div_in ? SrcA : SrcB};
      cnt_q  <= '0;
      if (!iter_req) res_q <= alu_r;
    end else if (state_q == BUSY) begin
      acc_q <= step_nx;
      cnt_q <= cnt_q + 1'b1;
      if (last) res_q <= iter_res;
    end
  end
endmodule

// File: tb/tb_muldiv_alu.sv
// tb_muldiv_alu: directed table, corner sequences and random checks against an arithmetic model of muldiv_alu
module tb_muldiv_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [3:0]  ALUctrl = '0;
  logic        ready, done, EQ, LT, LTU;
  logic [31:0] ALUResult;
  int checks = 0, failures = 0;

  muldiv_alu #(.WIDTH(32), .SH_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .SrcA(SrcA), .SrcB(SrcB), .ALUctrl(ALUctrl), .start(start),
    .ready(ready), .done(done), .ALUResult(ALUResult), .EQ(EQ), .LT(LT), .LTU(LTU)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [31:0] res, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.lat = lat;
    return v;
  endfunction

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $signed(a) >>> b[4:0];
      4'd8:  return {31'b0, $signed(a) < $signed(b)};
      4'd9:  return {31'b0, a < b};
      4'd10: return p[31:0];
      4'd11: return p[63:32];
`ifdef MULDIV_ALU_DIV_EN
      4'd12: return b == 0 ? 32'hFFFF_FFFF : a / b;
      4'd13: return b == 0 ? a : a % b;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
`ifdef MULDIV_ALU_DIV_EN
    return (op >= 4'd10 && op <= 4'd13) ? 33 : 1;
`else
    return (op == 4'd10 || op == 4'd11) ? 33 : 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] er, input int el);
    int   lat;
    logic busy_rdy;
    SrcA = a; SrcB = b; ALUctrl = op; start = 1'b1;
    #1;
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    chk({nm, "_eq"}, 32'(EQ), 32'(a == b));
    chk({nm, "_lt"}, 32'(LT), 32'($signed(a) < $signed(b)));
    chk({nm, "_ltu"}, 32'(LTU), 32'(a < b));
    @(posedge clk); #1;
    start = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUctrl = 4'($urandom);
    lat = 1; busy_rdy = 1'b0;
    while (!done && lat < 200) begin
      if (ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(el));
    chk({nm, "_result"}, ALUResult, er);
    if (el > 1) chk({nm, "_ready_in_busy"}, 32'(busy_rdy), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_held"}, ALUResult, er);
  endtask

  initial begin
    int   dn;
    logic [31:0] got;
    logic [31:0] a, b;
    logic [3:0]  op;
    vecs[0]  = mk(32'hFFFF_FFFF, 32'h1,        4'b0000, 32'h0000_0000, 1);
    vecs[1]  = mk(32'h5,         32'h7,        4'b0001, 32'hFFFF_FFFE, 1);
    vecs[2]  = mk(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0010, 32'hF000_F000, 1);
    vecs[3]  = mk(32'hF0F0_F0F0, 32'h0F0F_0000, 4'b0011, 32'hFFFF_F0F0, 1);
    vecs[4]  = mk(32'hAAAA_AAAA, 32'hFFFF_FFFF, 4'b0100, 32'h5555_5555, 1);
    vecs[5]  = mk(32'h1,         32'h21,       4'b0101, 32'h0000_0002, 1);
    vecs[6]  = mk(32'h8000_0000, 32'h1F,       4'b0110, 32'h0000_0001, 1);
    vecs[7]  = mk(32'h8000_0000, 32'h24,       4'b0111, 32'hF800_0000, 1);
    vecs[8]  = mk(32'hFFFF_FFFF, 32'h1,        4'b1000, 32'h1, 1);
    vecs[9]  = mk(32'hFFFF_FFFF, 32'h1,        4'b1001, 32'h0, 1);
    vecs[10] = mk(32'h7,         32'h9,        4'b1010, 32'h3F, 33);
    vecs[11] = mk(32'h1_0000,    32'h1_0003,   4'b1010, 32'h0003_0000, 33);
    vecs[12] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1011, 32'hFFFF_FFFE, 33);
    vecs[13] = mk(32'h1_0000,    32'h1_0003,   4'b1011, 32'h1, 33);
    vecs[14] = mk(32'h1234,      32'h5678,     4'b1110, 32'h0, 1);
    vecs[15] = mk(32'hFFFF_FFFF, 32'h1,        4'b1111, 32'h0, 1);
`ifdef MULDIV_ALU_DIV_EN
    vecs[16] = mk(32'd100, 32'd7, 4'b1100, 32'd14, 33);
    vecs[17] = mk(32'd100, 32'd7, 4'b1101, 32'd2, 33);
    vecs[18] = mk(32'd5,   32'd0, 4'b1100, 32'hFFFF_FFFF, 33);
    vecs[19] = mk(32'd5,   32'd0, 4'b1101, 32'd5, 33);
`else
    vecs[16] = mk(32'd100, 32'd7, 4'b1100, 32'd0, 1);
    vecs[17] = mk(32'd100, 32'd7, 4'b1101, 32'd0, 1);
    vecs[18] = mk(32'd5,   32'd0, 4'b1100, 32'd0, 1);
    vecs[19] = mk(32'd5,   32'd0, 4'b1101, 32'd0, 1);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", ALUResult, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_done", 32'(done), 32'd0);
    for (int i = 0; i < 20; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].lat);
    // start held high through BUSY while SrcA keeps changing
    SrcA = 32'd7; SrcB = 32'd9; ALUctrl = 4'b1010; start = 1'b1;
    @(posedge clk); #1;
    dn = 0; got = '0;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        dn++;
        got = ALUResult;
        start = 1'b0;
      end else begin
        SrcA = $urandom;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("hold_start_done_count", 32'(dn), 32'd1);
    chk("hold_start_result", got, 32'h3F);
    // reset in the middle of a multiply
    SrcA = 32'd3; SrcB = 32'd5; ALUctrl = 4'b1010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", ALUResult, 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("abort_no_late_done", 32'(dn), 32'd0);
    // reset wins over a simultaneous start
    SrcA = 32'd1; SrcB = 32'd2; ALUctrl = 4'b0000; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_prio_no_done", 32'(done), 32'd0);
    chk("rst_prio_result", ALUResult, 32'd0);
    // random operations against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = a;
        2:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), a, b, op, ref_res(a, b, op), ref_lat(op));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_alu.md
MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter SH_WIDTH, default 5: shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port SrcA, input, WIDTH bits: operand A.
REQ-006 SHALL have port SrcB, input, WIDTH bits: operand B.
REQ-007 SHALL have port ALUctrl, input, 4 bits: operation select.
REQ-008 SHALL have port start, input, 1 bit: request; accepted only while ready=1.
REQ-009 SHALL have port ready, output, 1 bit: high in IDLE only.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when ALUResult is updated.
REQ-011 SHALL have port ALUResult, output, WIDTH bits: registered result, held until the next done.
REQ-012 SHALL have ports EQ, LT and LTU, outputs, 1 bit each: combinational SrcA==SrcB, signed SrcA<SrcB and unsigned SrcA<SrcB, valid in every state.

Function
REQ-013 SHALL decode ALUctrl as follows; unlisted codes yield 0:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
- 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- 1010 MUL (low word), 1011 MULHU (high word, unsigned)
- 1100 DIVU, 1101 REMU
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE:
- IDLE, start with a single-cycle op -> DONE
- IDLE, start with MUL/MULHU/DIVU/REMU -> BUSY
- BUSY, iteration counter = WIDTH-1 -> DONE
- DONE -> IDLE unconditionally
REQ-015 SHALL capture SrcA, SrcB and ALUctrl on acceptance; later input changes SHALL NOT affect the in-flight result.
REQ-016 SHALL give single-cycle ops a latency of 1: done and the new ALUResult appear in the cycle after acceptance.
REQ-017 SHALL give iterative ops a latency of WIDTH+1 cycles from acceptance to done.
REQ-018 SHALL compute MUL/MULHU by one shift-add step per BUSY cycle, forming a 2*WIDTH-bit product.
REQ-019 SHALL compute DIVU/REMU by one restoring-division step per BUSY cycle.
REQ-020 SHALL use only SrcB[SH_WIDTH-1:0] as the shift amount; SRA SHALL sign-fill.
REQ-021 SHALL produce all ones for DIVU with divisor 0, and SrcA for REMU with divisor 0, each at normal latency.
REQ-022 SHALL ignore start while ready=0; there is no queueing.
REQ-023 SHALL truncate ADD/SUB/MUL modulo 2^WIDTH and provide no overflow flag.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, iteration counter 0, ALUResult 0 and done 0, giving ready=1 in the next cycle.
REQ-025 SHALL abort any in-flight operation when rst asserts in BUSY or DONE: no done pulse and no result update.
REQ-026 SHALL give rst priority over start in the same cycle.

Configuration
REQ-027 SHALL, when MULDIV_ALU_DIV_EN is defined, include the divider and implement DIVU/REMU per REQ-019 and REQ-021.
REQ-028 SHALL, when MULDIV_ALU_DIV_EN is undefined, omit all divider logic and treat codes 1100/1101 as unlisted, giving result 0 with single-cycle latency.

Verification
REQ-029 Bench SHALL check ADD: SrcA=0xFFFFFFFF, SrcB=1, start -> next cycle done=1, ALUResult=0x00000000; EQ=0, LTU=0 during the request.
REQ-030 Bench SHALL check SRA: SrcA=0x80000000, SrcB=0x00000024 -> ALUResult=0xF8000000, since only the 5-bit amount 4 is used.
REQ-031 Bench SHALL check MULHU: SrcA=SrcB=0xFFFFFFFF -> done exactly 33 cycles after acceptance, ALUResult=0xFFFFFFFE, ready=0 throughout BUSY.
REQ-032 Bench SHALL check, with MULDIV_ALU_DIV_EN defined:
- DIVU 100/7 -> 14
- REMU 100/7 -> 2
- DIVU 5/0 -> 0xFFFFFFFF
- REMU 5/0 -> 5
REQ-033 Bench SHALL check abort: start MUL, assert rst for 1 cycle at BUSY cycle 10 -> no done pulse, ALUResult=0, ready=1 in the cycle after rst is released.
REQ-034 Bench SHALL check start held high during BUSY with changing SrcA -> exactly one done, with the result computed from the captured operands.
